// File: rtl/if_fetch_if.sv
// if_fetch_if: instruction-memory req/ack port and the decode valid/ready handshake of the fetch stage.
interface if_fetch_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic [31:0]     instr;
  logic            instr_valid;
  logic            instr_ready;
  modport master (
    output imem_req, imem_addr, instr, instr_valid,
    input  imem_ack, imem_rdata, instr_ready
  );
  modport slave (
    input  imem_req, imem_addr, instr, instr_valid,
    output imem_ack, imem_rdata, instr_ready
  );
endinterface

// File: rtl/if_fetch.sv
// if_fetch: fetch stage between the PC register and decode; optional misaligned-fetch trap under IF_MISALIGN_TRAP_EN.
module if_fetch #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  output logic            pc_hold_o,
  input  logic            flush_i,
  output logic            fault_o,
  if_fetch_if.master      bus_io
);
`ifdef IF_MISALIGN_TRAP_EN
  typedef enum logic [2:0] {IDLE, REQ, HOLD, DRAIN, FAULT} state_t;
`else
  typedef enum logic [2:0] {IDLE, REQ, HOLD, DRAIN} state_t;
`endif
  state_t          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d, fetch_pc;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q;
`ifdef IF_MISALIGN_TRAP_EN
  assign fetch_pc = pc_i;
  assign fault_o  = state_q == FAULT;
`else
  assign fetch_pc = pc_i & ~XLEN'(3);
  assign fault_o  = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      instr_q <= NOP_INSN;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      valid_q <= state_d == HOLD;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
`ifdef IF_MISALIGN_TRAP_EN
      IDLE:    state_d = flush_i ? IDLE : (|pc_i[1:0]) ? FAULT : REQ;
      FAULT:   state_d = flush_i ? IDLE : FAULT;
`else
      IDLE:    state_d = flush_i ? IDLE : REQ;
`endif
      REQ:     state_d = flush_i ? (bus_io.imem_ack ? IDLE : DRAIN) : bus_io.imem_ack ? HOLD : REQ;
      HOLD:    state_d = (flush_i || bus_io.instr_ready) ? IDLE : HOLD;
      DRAIN:   state_d = bus_io.imem_ack ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  // Data is captured only from an unflushed ack; acks in other states are ignored.
  always_comb begin
    addr_d    = state_q == IDLE ? fetch_pc : addr_q;
    instr_d   = (state_q == REQ && bus_io.imem_ack && !flush_i) ? bus_io.imem_rdata : instr_q;
    pc_hold_o = !rst || !((state_q == HOLD && bus_io.instr_ready) || flush_i);
  end
  assign bus_io.imem_req    = state_q == REQ || state_q == DRAIN;
  assign bus_io.imem_addr   = addr_q;
  assign bus_io.instr       = instr_q;
  assign bus_io.instr_valid = valid_q;
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed fetch sequences; a scoreboard checks every instruction accepted by decode.
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] pc = '0;
  logic        pc_hold, fault;
  logic [63:0] sb[$];
  logic [63:0] mon_e;
  int          checks = 0;
  int          failures = 0;

  if_fetch_if #(.XLEN(32)) bus ();
  if_fetch #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .pc_i(pc), .pc_hold_o(pc_hold),
    .flush_i(flush), .fault_o(fault), .bus_io(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  // Monitor: every accepted instruction must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst && bus.instr_valid && bus.instr_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_instr: got %h expected none", bus.instr);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_instr", bus.instr, mon_e[31:0]);
        chk("sb_addr", bus.imem_addr, mon_e[63:32]);
      end
    end
  end

  // IDLE cycle with a stray ack that must be ignored.
  task automatic idle_cyc(logic [31:0] p);
    pc = p;
    flush = 1'b0;
    bus.instr_ready = 1'b0;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hDEAD_0001;
    samp();
    chk("idle_req", bus.imem_req, 0);
    chk("idle_valid", bus.instr_valid, 0);
    chk("idle_hold", pc_hold, 1);
    chk("idle_fault", fault, 0);
    tick();
    bus.imem_ack = 1'b0;
  endtask

  task automatic serve(logic [31:0] a, int adly, logic [31:0] d, int rdly);
    for (int i = 0; i <= adly; i++) begin
      bus.imem_ack = (i == adly);
      bus.imem_rdata = (i == adly) ? d : 32'hDEAD_0002;
      samp();
      chk("req_req", bus.imem_req, 1);
      chk("req_addr", bus.imem_addr, a);
      chk("req_valid", bus.instr_valid, 0);
      chk("req_hold", pc_hold, 1);
      tick();
    end
    sb.push_back({a, d});
    for (int i = 0; i <= rdly; i++) begin
      bus.instr_ready = (i == rdly);
      bus.imem_ack = (i != rdly);
      bus.imem_rdata = 32'hDEAD_0003;
      samp();
      chk("hold_valid", bus.instr_valid, 1);
      chk("hold_instr", bus.instr, d);
      chk("hold_req", bus.imem_req, 0);
      chk("hold_pchold", pc_hold, (i != rdly) ? 32'd1 : 32'd0);
      tick();
    end
    bus.instr_ready = 1'b0;
    bus.imem_ack = 1'b0;
  endtask

  task automatic fetch(logic [31:0] p, logic [31:0] a, int adly, logic [31:0] d, int rdly);
    idle_cyc(p);
    serve(a, adly, d, rdly);
  endtask

  initial begin
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    bus.instr_ready = 1'b0;
    tick();
    samp();
    chk("rst_req", bus.imem_req, 0);
    chk("rst_addr", bus.imem_addr, 0);
    chk("rst_instr", bus.instr, 32'h0000_0013);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_fault", fault, 0);
    chk("rst_hold", pc_hold, 1);
    tick();
    rst = 1'b1;
    fetch(32'h0, 32'h0, 0, 32'h0050_0093, 0);
    fetch(32'h4, 32'h4, 4, 32'h00A1_2023, 0);
    fetch(32'h8, 32'h8, 0, 32'h0020_8133, 3);
    // Flush in REQ, ack two cycles later; a second flush in DRAIN is absorbed.
    idle_cyc(32'hC);
    flush = 1'b1;
    samp();
    chk("flreq_req", bus.imem_req, 1);
    chk("flreq_hold", pc_hold, 0);
    tick();
    pc = 32'h40;
    for (int i = 0; i < 2; i++) begin
      flush = (i == 0);
      bus.imem_ack = (i == 1);
      bus.imem_rdata = 32'hBAD0_0001;
      samp();
      chk("drain_req", bus.imem_req, 1);
      chk("drain_addr", bus.imem_addr, 32'hC);
      chk("drain_valid", bus.instr_valid, 0);
      tick();
    end
    flush = 1'b0;
    bus.imem_ack = 1'b0;
    fetch(32'h40, 32'h40, 0, 32'h0000_0297, 0);
    // Flush and ack in the same REQ cycle go straight back to IDLE.
    idle_cyc(32'h50);
    flush = 1'b1;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hBAD0_0002;
    samp();
    chk("flack_hold", pc_hold, 0);
    tick();
    flush = 1'b0;
    bus.imem_ack = 1'b0;
    fetch(32'h60, 32'h60, 1, 32'h0041_0113, 0);
    // Flush together with ready in HOLD.
    idle_cyc(32'h70);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'h00C0_006F;
    samp();
    tick();
    bus.imem_ack = 1'b0;
    sb.push_back({32'h70, 32'h00C0_006F});
    bus.instr_ready = 1'b1;
    flush = 1'b1;
    samp();
    chk("flhold_valid", bus.instr_valid, 1);
    chk("flhold_hold", pc_hold, 0);
    tick();
    bus.instr_ready = 1'b0;
    flush = 1'b0;
    fetch(32'h200, 32'h200, 0, 32'h0010_0073, 0);
    // Flush without ready in HOLD drops the instruction.
    idle_cyc(32'h210);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hBAD0_0003;
    samp();
    tick();
    bus.imem_ack = 1'b0;
    flush = 1'b1;
    samp();
    chk("flnr_valid", bus.instr_valid, 1);
    chk("flnr_hold", pc_hold, 0);
    tick();
    flush = 1'b0;
    fetch(32'h300, 32'h300, 0, 32'h0030_0193, 0);
    // Reset mid-fetch, then a late ack in IDLE.
    idle_cyc(32'h400);
    rst = 1'b0;
    samp();
    chk("mrst_hold", pc_hold, 1);
    tick();
    rst = 1'b1;
    pc = 32'h404;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hBAD0_0004;
    samp();
    chk("mrst_req", bus.imem_req, 0);
    chk("mrst_addr", bus.imem_addr, 0);
    chk("mrst_instr", bus.instr, 32'h0000_0013);
    chk("mrst_valid", bus.instr_valid, 0);
    tick();
    bus.imem_ack = 1'b0;
    serve(32'h404, 0, 32'h0040_0213, 0);
`ifdef IF_MISALIGN_TRAP_EN
    idle_cyc(32'h102);
    for (int i = 0; i < 2; i++) begin
      samp();
      chk("flt_fault", fault, 1);
      chk("flt_req", bus.imem_req, 0);
      tick();
    end
    flush = 1'b1;
    pc = 32'h100;
    samp();
    chk("flt_flush_hold", pc_hold, 0);
    tick();
    flush = 1'b0;
    fetch(32'h100, 32'h100, 0, 32'h0050_0293, 0);
`else
    fetch(32'h102, 32'h100, 0, 32'h0050_0293, 0);
`endif
    tick();
    tick();
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage that sits directly downstream of the PC register in the single-cycle RISC-V core. It takes the current `pc`, fetches the instruction over a req/ack instruction-memory port, and presents it to decode with a valid/ready handshake. It drives `pc_hold` back to the PC_Next mux, so the PC advances only when decode accepts an instruction or a redirect (`flush`) occurs.

## Interface
- `XLEN`, 32, address/data width
- `NOP_INSN`, 32'h0000_0013, reset value of `instr` (addi x0,x0,0)

- `clk` in 1: clock, rising edge
- `rst` in 1: reset, synchronous, active-low
- `pc` in XLEN: current PC from the PC register
- `pc_hold` out 1: 1 = upstream must feed PC_Next = pc (hold)
- `flush` in 1: one-cycle redirect; upstream loads the branch target into PC on the same edge
- `imem_req` out 1: fetch request
- `imem_addr` out XLEN: fetch address, registered
- `imem_ack` in 1: one-cycle acknowledge; `imem_rdata` valid in the same cycle
- `imem_rdata` in 32: fetched word
- `instr` out 32: instruction to decode, registered
- `instr_valid` out 1: `instr` valid
- `instr_ready` in 1: decode accepts `instr`
- `fault` out 1: misaligned-fetch fault (see Configuration)

## Operation
- States: IDLE, REQ, HOLD, DRAIN, FAULT (FAULT exists only with the macro).
- IDLE: `imem_addr <= pc`. Next state is REQ, or IDLE if `flush`=1. With the macro, `pc[1:0]`≠0 and no flush goes to FAULT instead.
- REQ: `imem_req`=1 and `imem_addr` stable.
  - On `imem_ack` without flush: `instr <= imem_rdata`, `instr_valid <= 1`, go to HOLD.
  - On flush with ack in the same cycle: discard data, go to IDLE.
  - On flush without ack: go to DRAIN.
- HOLD: `instr`/`instr_valid` stay stable until `instr_ready`.
  - `instr_ready`=1 without flush: `instr_valid <= 0`, go to IDLE.
  - `flush`=1 (overrides ready): `instr_valid <= 0`, go to IDLE.
- DRAIN: `imem_req` stays 1 with the old address; a request is never withdrawn before ack. On `imem_ack`, discard data and go to IDLE. `flush` in DRAIN is absorbed.
- FAULT: `fault`=1, `imem_req`=0. `flush` returns to IDLE and clears `fault`.
- `pc_hold` (combinational) = NOT((state==HOLD AND `instr_ready`) OR `flush`). It is also 1 while `rst`=0.
- `imem_req` is a registered/state-decoded output: 1 in REQ and DRAIN only.

## Timing
- Reset values: state IDLE, `imem_req` 0, `imem_addr` 0, `instr` NOP_INSN, `instr_valid` 0, `fault` 0.
- Reset asserted mid-fetch aborts immediately. Any outstanding ack after reset is ignored because state is IDLE.
- Minimum 3 cycles per instruction (IDLE, REQ with ack, HOLD with ready). Each cycle `imem_ack` is late adds 1; each cycle `instr_ready` is low adds 1.
- PC advances on the same edge that the HOLD handshake completes. The next IDLE samples the new `pc`.
- `imem_ack` in IDLE/HOLD/FAULT is a protocol error and is ignored.
- `instr_valid` is never 1 in any state other than HOLD.

## Configuration
- `IF_MISALIGN_TRAP_EN` defined: IDLE checks `pc[1:0]`. If nonzero, go to FAULT with no memory request and `fault` asserted until `flush`.
- Not defined: FAULT state is not built, `fault` is tied 0, and `imem_addr[1:0]` is forced to 2'b00 (low PC bits ignored).

## Test plan
- Reset with `rst`=0 for 2 cycles, then release, `pc`=0x0, ack in 1st REQ cycle returning 0x00500093, ready=1 → `imem_addr`=0x0, `instr`=0x00500093 with `instr_valid` for 1 cycle, `pc_hold`=0 for exactly that cycle, 3-cycle period.
- Ack delayed 4 cycles, `imem_rdata`=0x00A12023 → `imem_req` held 5 cycles with constant `imem_addr`, then `instr`=0x00A12023.
- `instr_ready`=0 for 3 cycles in HOLD → `instr` and `instr_valid` stable, `pc_hold`=1 throughout, `imem_req`=0.
- `flush` in REQ with ack 2 cycles later → DRAIN, returned data never appears on `instr`, next fetch uses the new `pc` (e.g. 0x40).
- `flush` with `instr_ready` in HOLD → `instr_valid` drops, `pc_hold`=0 that cycle, next `imem_addr` = target.
- Macro on, `pc`=0x102 → `fault`=1, no `imem_req`; `flush` with `pc`=0x100 → fault clears, fetch 0x100. Macro off, same `pc` → `imem_addr`=0x100, `fault`=0.
